otter_reorder_buffer: RTL and testbench

// In-order retirement buffer for the dual-issue OOO OTTER. Dispatch allocates up to two entries
// per cycle; two completion (CDB) ports post results by tag; the oldest completed entry retires
// one per cycle onto the register file's single write port (rf_we/rf_waddr/rf_wdata).

---
 rtl/otter_reorder_buffer.sv | 125 ++++++++++++
 tb/tb_otter_reorder_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_reorder_buffer.sv
// In-order retirement buffer for the dual-issue OTTER: allocates up to two entries per cycle,
// accepts results on two CDB ports by tag, retires the oldest completed entry onto the RF write port.
module otter_reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             alloc0_valid,
  input  logic             alloc0_wen,
  input  logic [4:0]       alloc0_rd,
  input  logic             alloc1_valid,
  input  logic             alloc1_wen,
  input  logic [4:0]       alloc1_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc0_tag,
  output logic [TAG_W-1:0] alloc1_tag,
  input  logic             cdb0_valid,
  input  logic [TAG_W-1:0] cdb0_tag,
  input  logic [31:0]      cdb0_data,
  input  logic             cdb1_valid,
  input  logic [TAG_W-1:0] cdb1_tag,
  input  logic [31:0]      cdb1_data,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_tag,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [TAG_W:0]   count,
  output logic             empty
);

  localparam logic [TAG_W:0] ALLOC_LIMIT = (TAG_W+1)'(DEPTH - 2);

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] ent_wen;
  logic [4:0]       ent_rd   [DEPTH];
  logic [31:0]      ent_data [DEPTH];

  logic             do_alloc0;
  logic             do_alloc1;
  logic             cdb0_hit;
  logic             cdb1_hit;
  logic [TAG_W-1:0] tail_inc;
  logic [TAG_W-1:0] tail_next;
  logic [TAG_W:0]   count_next;

  // Readiness uses the registered count, so a slot freed by this cycle's commit waits a cycle.
  assign alloc_ready = (count <= ALLOC_LIMIT);
  assign empty       = (count == '0);
  assign tail_inc    = tail + TAG_W'(1);
  assign alloc0_tag  = tail;
  assign alloc1_tag  = tail_inc;

  assign do_alloc0 = alloc_ready & alloc0_valid & ~flush;
  assign do_alloc1 = do_alloc0 & alloc1_valid;

  // Port 0 wins on a shared tag; completions only land on live, not-yet-done entries.
  assign cdb0_hit = cdb0_valid & ~flush & ent_valid[cdb0_tag] & ~ent_done[cdb0_tag];
  assign cdb1_hit = cdb1_valid & ~flush & ent_valid[cdb1_tag] & ~ent_done[cdb1_tag]
                    & ~(cdb0_valid & (cdb0_tag == cdb1_tag));

  assign commit_valid = ent_valid[head] & ent_done[head] & ~flush;
  assign commit_tag   = commit_valid ? head : '0;
  assign rf_we        = commit_valid & ent_wen[head] & (ent_rd[head] != 5'd0);
  assign rf_waddr     = rf_we ? ent_rd[head] : 5'd0;
  assign rf_wdata     = rf_we ? ent_data[head] : 32'd0;

  assign tail_next  = tail + TAG_W'(do_alloc0) + TAG_W'(do_alloc1);
  assign count_next = count + (TAG_W+1)'(do_alloc0) + (TAG_W+1)'(do_alloc1)
                      - (TAG_W+1)'(commit_valid);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      if (commit_valid) begin
        ent_valid[head] <= 1'b0;
        ent_done[head]  <= 1'b0;
        head            <= head + TAG_W'(1);
      end
      if (cdb1_hit) ent_done[cdb1_tag] <= 1'b1;
      if (cdb0_hit) ent_done[cdb0_tag] <= 1'b1;
      if (do_alloc0) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
      end
      if (do_alloc1) begin
        ent_valid[tail_inc] <= 1'b1;
        ent_done[tail_inc]  <= 1'b0;
      end
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Payload storage carries no reset; entry valid/done bits qualify every read.
  always_ff @(posedge clock) begin
    if (cdb1_hit) ent_data[cdb1_tag] <= cdb1_data;
    if (cdb0_hit) ent_data[cdb0_tag] <= cdb0_data;
    if (do_alloc0) begin
      ent_wen[tail] <= alloc0_wen;
      ent_rd[tail]  <= alloc0_rd;
    end
    if (do_alloc1) begin
      ent_wen[tail_inc] <= alloc1_wen;
      ent_rd[tail_inc]  <= alloc1_rd;
    end
  end

endmodule

// File: tb/tb_otter_reorder_buffer.sv
// Bench for otter_reorder_buffer: directed scenarios plus random traffic against a queue-based
// model; expected retirements go to a scoreboard queue that a separate monitor drains.
module tb_otter_reorder_buffer;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;
  localparam int W     = TAG_W + 38;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush;
  logic             alloc0_valid, alloc0_wen, alloc1_valid, alloc1_wen;
  logic [4:0]       alloc0_rd, alloc1_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc0_tag, alloc1_tag;
  logic             cdb0_valid, cdb1_valid;
  logic [TAG_W-1:0] cdb0_tag, cdb1_tag;
  logic [31:0]      cdb0_data, cdb1_data;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic [TAG_W:0]   count;
  logic             empty;

  always #5 clock = ~clock;

  otter_reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .alloc0_valid(alloc0_valid), .alloc0_wen(alloc0_wen), .alloc0_rd(alloc0_rd),
    .alloc1_valid(alloc1_valid), .alloc1_wen(alloc1_wen), .alloc1_rd(alloc1_rd),
    .alloc_ready(alloc_ready), .alloc0_tag(alloc0_tag), .alloc1_tag(alloc1_tag),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .count(count), .empty(empty)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             wen;
    logic [4:0]       rd;
    logic             done;
    logic [31:0]      data;
  } ent_t;

  ent_t       rob_q[$];
  int         tail_m = 0;
  logic [W-1:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs;
    flush = 0;
    alloc0_valid = 0; alloc0_wen = 0; alloc0_rd = 0;
    alloc1_valid = 0; alloc1_wen = 0; alloc1_rd = 0;
    cdb0_valid = 0; cdb0_tag = 0; cdb0_data = 0;
    cdb1_valid = 0; cdb1_tag = 0; cdb1_data = 0;
  endtask

  task automatic set_alloc(input bit v0, input bit w0, input logic [4:0] r0,
                           input bit v1, input bit w1, input logic [4:0] r1);
    alloc0_valid = v0; alloc0_wen = w0; alloc0_rd = r0;
    alloc1_valid = v1; alloc1_wen = w1; alloc1_rd = r1;
  endtask

  task automatic set_cdb(input int port, input logic [TAG_W-1:0] t, input logic [31:0] d);
    if (port == 0) begin
      cdb0_valid = 1; cdb0_tag = t; cdb0_data = d;
    end else begin
      cdb1_valid = 1; cdb1_tag = t; cdb1_data = d;
    end
  endtask

  task automatic model_complete(input logic [TAG_W-1:0] t, input logic [31:0] d);
    ent_t e;
    for (int i = 0; i < rob_q.size(); i++) begin
      if (rob_q[i].tag == t && !rob_q[i].done) begin
        e = rob_q[i];
        e.done = 1;
        e.data = d;
        rob_q[i] = e;
      end
    end
  endtask

  task automatic push_entry(input bit w, input logic [4:0] r);
    ent_t e;
    e.tag = TAG_W'(tail_m);
    e.wen = w;
    e.rd = r;
    e.done = 0;
    e.data = 0;
    rob_q.push_back(e);
    tail_m = (tail_m + 1) % DEPTH;
  endtask

  // One clock cycle: called at a negedge with inputs applied; checks status outputs,
  // queues any expected retirement, advances the model, and returns at the next negedge.
  task automatic step;
    bit   ready_m, commit_m, we;
    ent_t e;
    #1;
    ready_m = (DEPTH - rob_q.size()) >= 2;
    check("alloc_ready", alloc_ready, ready_m);
    check("alloc0_tag", alloc0_tag, tail_m);
    check("alloc1_tag", alloc1_tag, (tail_m + 1) % DEPTH);
    check("count", count, rob_q.size());
    check("empty", empty, rob_q.size() == 0);
    commit_m = !flush && rob_q.size() > 0 && rob_q[0].done;
    if (commit_m) begin
      e = rob_q[0];
      we = e.wen && (e.rd != 0);
      exp_q.push_back({e.tag, we, we ? e.rd : 5'd0, we ? e.data : 32'd0});
    end
    if (flush) begin
      rob_q.delete();
      tail_m = 0;
    end else begin
      if (cdb0_valid) model_complete(cdb0_tag, cdb0_data);
      if (cdb1_valid) model_complete(cdb1_tag, cdb1_data);
      if (commit_m) void'(rob_q.pop_front());
      if (ready_m && alloc0_valid) begin
        push_entry(alloc0_wen, alloc0_rd);
        if (alloc1_valid) push_entry(alloc1_wen, alloc1_rd);
      end
    end
    @(negedge clock);
  endtask

  task automatic do_flush;
    clear_inputs;
    flush = 1;
    step;
    clear_inputs;
  endtask

  task automatic random_cycle;
    int pend[$];
    clear_inputs;
    set_alloc($urandom_range(0, 1), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
              $urandom_range(0, 1), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)));
    foreach (rob_q[i]) if (!rob_q[i].done) pend.push_back(int'(rob_q[i].tag));
    if (pend.size() > 0 && $urandom_range(0, 3) != 0)
      set_cdb(0, TAG_W'(pend[$urandom_range(0, pend.size() - 1)]), $urandom);
    else if ($urandom_range(0, 3) == 0)
      set_cdb(0, TAG_W'($urandom_range(0, DEPTH - 1)), $urandom);
    if (cdb0_valid && $urandom_range(0, 7) == 0)
      set_cdb(1, cdb0_tag, $urandom);
    else if (pend.size() > 0 && $urandom_range(0, 1) != 0)
      set_cdb(1, TAG_W'(pend[$urandom_range(0, pend.size() - 1)]), $urandom);
    flush = ($urandom_range(0, 59) == 0);
    step;
  endtask

  // Retirement monitor: compares each presented commit against the scoreboard queue.
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(negedge clock);
      #2;
      if (!reset_n) continue;
      if (commit_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_commit: got tag %0d rf_we %0b addr %0d data 0x%0h, expected no commit",
                   commit_tag, rf_we, rf_waddr, rf_wdata);
        end else begin
          exp = exp_q.pop_front();
          check("commit", {commit_tag, rf_we, rf_waddr, rf_wdata}, exp);
        end
      end else begin
        check("idle_rf", {rf_we, rf_waddr, rf_wdata}, 0);
        if (exp_q.size() != 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing_commit: got no commit, expected 0x%0h", exp_q[0]);
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    clear_inputs;
    repeat (2) @(negedge clock);
    check("reset_count", count, 0);
    check("reset_empty", empty, 1);
    check("reset_alloc_ready", alloc_ready, 1);
    check("reset_commit_valid", commit_valid, 0);
    check("reset_rf_we", rf_we, 0);
    reset_n = 1;

    // Out-of-order completion of a dual allocation retires in order.
    set_alloc(1, 1, 5'd5, 1, 1, 5'd6); step;
    clear_inputs; step;
    set_cdb(1, 1, 32'hBB); step;
    clear_inputs; step;
    set_cdb(0, 0, 32'hAA); step;
    clear_inputs; repeat (3) step;

    // Fill to full, ignored fifth pair, then tag wrap after two commits.
    do_flush;
    repeat (5) begin
      set_alloc(1, 1, 5'($urandom_range(1, 31)), 1, 1, 5'($urandom_range(1, 31)));
      step;
    end
    clear_inputs;
    set_cdb(0, 0, $urandom); set_cdb(1, 1, $urandom); step;
    clear_inputs; step; step;
    set_alloc(1, 1, 5'd9, 1, 1, 5'd10); step;
    clear_inputs; step;

    // rd = 0 and wen = 0 entries retire without a register write.
    do_flush;
    set_alloc(1, 1, 5'd0, 1, 0, 5'd7); step;
    clear_inputs;
    set_cdb(0, 0, $urandom); set_cdb(1, 1, $urandom); step;
    clear_inputs; repeat (3) step;

    // Commit and dual allocation in the same cycle at count 6.
    do_flush;
    repeat (3) begin
      set_alloc(1, 1, 5'($urandom_range(1, 31)), 1, 1, 5'($urandom_range(1, 31)));
      step;
    end
    clear_inputs; set_cdb(0, 0, 32'h1234); step;
    set_alloc(1, 1, 5'd11, 1, 1, 5'd12); step;
    clear_inputs; step;

    // Flush beats a same-cycle completion of the head.
    do_flush;
    set_alloc(1, 1, 5'd1, 1, 1, 5'd2); step; step;
    set_alloc(1, 1, 5'd3, 0, 0, 5'd0); step;
    clear_inputs; set_cdb(0, 1, $urandom); set_cdb(1, 2, $urandom); step;
    clear_inputs; set_cdb(0, 3, $urandom); step;
    clear_inputs; flush = 1; set_cdb(0, 0, 32'hDEAD); step;
    clear_inputs; step;

    // Asynchronous reset in the middle of a run with five entries.
    set_alloc(1, 1, 5'd4, 1, 1, 5'd5); step; step;
    set_alloc(1, 1, 5'd6, 0, 0, 5'd0); step;
    clear_inputs; step;
    #3 reset_n = 0;
    #1;
    check("async_reset_count", count, 0);
    check("async_reset_empty", empty, 1);
    check("async_reset_rf_we", rf_we, 0);
    check("async_reset_alloc_ready", alloc_ready, 1);
    check("async_reset_commit_valid", commit_valid, 0);
    rob_q.delete();
    tail_m = 0;
    @(negedge clock);
    reset_n = 1;
    set_alloc(1, 1, 5'd8, 0, 0, 5'd0); step;

    repeat (3000) random_cycle;

    // Drain: complete the oldest pending entry each cycle until the model is empty.
    for (k = 0; k < 100 && rob_q.size() > 0; k++) begin
      clear_inputs;
      foreach (rob_q[i]) begin
        if (!rob_q[i].done && !cdb0_valid) set_cdb(0, rob_q[i].tag, $urandom);
      end
      step;
    end
    if (rob_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d entries left, expected 0", rob_q.size());
    end
    clear_inputs; step;
    #3;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
